spi_subperipheral_controller: RTL and testbench

Registered transaction controller between `spi_peripheral` and up to four SPI register subperipherals. It replaces purely combinational address selection with a sequenced transaction. It decodes the address byte against a parameter table, holds one slot enabled for the whole chip-select window and issues a read request for every byte position. It also forwards each received data byte as a one-cycle write strobe with a per-transaction byte index, and returns 0xFF for unmapped addresses or unanswered reads.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_edge_detector.sv | 15 +
 rtl/spi_subperipheral_controller.sv | 151 +++++++++++++++
 tb/tb_spi_subperipheral_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI subperipheral controller
package spi_pkg;
  localparam int SPI_SLOT_COUNT = 4;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
  localparam logic [7:0] SPI_UNUSED_ADDRESS = 8'h00;
  typedef enum logic [2:0] {IDLE, DECODE, WAIT_READ, HOLD, MISS} spi_state_t;
endpackage

// File: rtl/spi_edge_detector.sv
// spi_edge_detector: one-cycle rise/fall pulses for a level input
module spi_edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic level_in,
  output logic rise_out,
  output logic fall_out
);
  logic r_prev;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_prev <= 1'b0;
    else r_prev <= level_in;
  assign rise_out = level_in & ~r_prev;
  assign fall_out = ~level_in & r_prev;
endmodule

// File: rtl/spi_subperipheral_controller.sv
// spi_subperipheral_controller: sequenced slot select, read requests and write strobes.
// SPI_CONTROLLER_TIMEOUT_EN builds the read timeout that answers 8'hFF for silent slots.
module spi_subperipheral_controller
  import spi_pkg::*;
#(
  parameter logic [7:0] SLOT_ADDRESSES [SPI_SLOT_COUNT] = '{8'hDB, 8'hB5, 8'h00, 8'h00},
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                address_in,
  input  logic                      address_in_valid,
  input  logic [7:0]                copi_in,
  input  logic                      copi_in_valid,
  output logic [7:0]                cipo_out,
  output logic                      cipo_out_valid,
  output logic [SPI_SLOT_COUNT-1:0] enable_out,
  output logic [7:0]                byte_index_out,
  output logic [7:0]                write_data_out,
  output logic                      write_valid_out,
  output logic                      read_request_out,
  input  logic [7:0]                read_data_in,
  input  logic                      read_valid_in
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end
  spi_state_t r_state, w_state;
  logic [7:0] r_address, w_address, r_cipo, w_cipo, r_index, w_index, r_wdata, w_wdata;
  logic [SPI_SLOT_COUNT-1:0] r_enable, w_enable, w_slot_en;
  logic r_cipo_valid, w_cipo_valid, r_wvalid, w_wvalid, r_req, w_req, r_advance, w_advance;
  logic w_addr_rise, w_addr_fall, w_copi_rise, w_copi_fall_unused, w_timeout;
  spi_edge_detector u_addr_edge (
    .clock(clock), .reset(reset), .level_in(address_in_valid),
    .rise_out(w_addr_rise), .fall_out(w_addr_fall)
  );
  spi_edge_detector u_copi_edge (
    .clock(clock), .reset(reset), .level_in(copi_in_valid),
    .rise_out(w_copi_rise), .fall_out(w_copi_fall_unused)
  );
`ifdef SPI_CONTROLLER_TIMEOUT_EN
  logic [7:0] r_count;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_count <= '0;
    else r_count <= (r_state == WAIT_READ) ? r_count + 8'd1 : '0;
  assign w_timeout = (r_count == 8'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif
  // descending scan so the lowest-numbered matching slot wins
  always_comb begin
    w_slot_en = '0;
    for (int i = SPI_SLOT_COUNT - 1; i >= 0; i--)
      if (SLOT_ADDRESSES[i] != SPI_UNUSED_ADDRESS && SLOT_ADDRESSES[i] == r_address) begin
        w_slot_en = '0;
        w_slot_en[i] = 1'b1;
      end
  end
  always_comb begin
    w_state = r_state;
    w_address = r_address;
    w_cipo = r_cipo;
    w_cipo_valid = r_cipo_valid;
    w_enable = r_enable;
    w_index = r_index;
    w_wdata = r_wdata;
    w_wvalid = 1'b0;
    w_req = 1'b0;
    w_advance = 1'b0;
    if (w_addr_fall) begin
      w_state = IDLE;
      w_cipo_valid = 1'b0;
      w_enable = '0;
      w_index = '0;
      w_wdata = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_address = w_addr_rise ? address_in : r_address;
          w_state = w_addr_rise ? DECODE : IDLE;
        end
        DECODE: begin
          if (|w_slot_en) begin
            w_enable = w_slot_en;
            w_index = '0;
            w_req = 1'b1;
            w_state = WAIT_READ;
          end else begin
            w_cipo = SPI_IDLE_BYTE;
            w_cipo_valid = 1'b1;
            w_enable = '0;
            w_state = MISS;
          end
        end
        WAIT_READ: begin
          if (read_valid_in || w_timeout) begin
            w_cipo = read_valid_in ? read_data_in : SPI_IDLE_BYTE;
            w_cipo_valid = 1'b1;
            w_state = HOLD;
          end
        end
        HOLD: begin
          // the write strobe shows the old index; the following request carries the new one
          if (r_advance) begin
            w_index = (r_index == 8'hFF) ? r_index : r_index + 8'd1;
            w_req = 1'b1;
            w_cipo_valid = 1'b0;
            w_state = WAIT_READ;
          end else if (w_copi_rise) begin
            w_wvalid = 1'b1;
            w_wdata = copi_in;
            w_advance = 1'b1;
          end
        end
        MISS: w_state = MISS;
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_address <= '0;
      r_cipo <= SPI_IDLE_BYTE;
      r_cipo_valid <= 1'b0;
      r_enable <= '0;
      r_index <= '0;
      r_wdata <= '0;
      r_wvalid <= 1'b0;
      r_req <= 1'b0;
      r_advance <= 1'b0;
    end else begin
      r_state <= w_state;
      r_address <= w_address;
      r_cipo <= w_cipo;
      r_cipo_valid <= w_cipo_valid;
      r_enable <= w_enable;
      r_index <= w_index;
      r_wdata <= w_wdata;
      r_wvalid <= w_wvalid;
      r_req <= w_req;
      r_advance <= w_advance;
    end
  assign cipo_out = r_cipo;
  assign cipo_out_valid = r_cipo_valid;
  assign enable_out = r_enable;
  assign byte_index_out = r_index;
  assign write_data_out = r_wdata;
  assign write_valid_out = r_wvalid;
  assign read_request_out = r_req;
endmodule

// File: tb/tb_spi_subperipheral_controller.sv
// tb_spi_subperipheral_controller: directed checks of decode, read, write, miss, deselect and reset
module tb_spi_subperipheral_controller;
  localparam int T = 16;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] address_in = '0, copi_in = '0, read_data_in = '0;
  logic address_in_valid = 1'b0, copi_in_valid = 1'b0, read_valid_in = 1'b0;
  logic [7:0] cipo_out, byte_index_out, write_data_out;
  logic cipo_out_valid, write_valid_out, read_request_out;
  logic [3:0] enable_out;
  int n_checks = 0, n_fail = 0, n_req = 0, n_wr = 0;
  int req0, wr0;
  spi_subperipheral_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .address_in(address_in), .address_in_valid(address_in_valid),
    .copi_in(copi_in), .copi_in_valid(copi_in_valid), .cipo_out(cipo_out),
    .cipo_out_valid(cipo_out_valid), .enable_out(enable_out), .byte_index_out(byte_index_out),
    .write_data_out(write_data_out), .write_valid_out(write_valid_out),
    .read_request_out(read_request_out), .read_data_in(read_data_in), .read_valid_in(read_valid_in)
  );
  always #5 clock = ~clock;
  always @(negedge clock)
    if (!reset) begin
      if (read_request_out) n_req++;
      if (write_valid_out) n_wr++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic start(input logic [7:0] a);
    address_in = a;
    address_in_valid = 1'b1;
    step(2);
  endtask
  task automatic answer(input logic [7:0] d);
    read_data_in = d;
    read_valid_in = 1'b1;
    step();
    read_valid_in = 1'b0;
  endtask
  task automatic deselect();
    address_in_valid = 1'b0;
    step();
  endtask
  task automatic send_byte(input logic [7:0] d, input logic [7:0] idx);
    copi_in = d;
    copi_in_valid = 1'b1;
    step();
    check("wr_strobe", write_valid_out, 1);
    check("wr_data", write_data_out, d);
    check("wr_index", byte_index_out, idx);
    copi_in_valid = 1'b0;
    step();
    check("next_req", read_request_out, 1);
    check("next_index", byte_index_out, (idx == 8'hFF) ? 8'hFF : idx + 8'd1);
    check("next_cipo_valid", cipo_out_valid, 0);
  endtask
  initial begin
    step(2);
    check("rst_cipo", cipo_out, 8'hFF);
    check("rst_valid", cipo_out_valid, 0);
    check("rst_enable", enable_out, 0);
    check("rst_index", byte_index_out, 0);
    check("rst_wdata", write_data_out, 0);
    check("rst_wvalid", write_valid_out, 0);
    check("rst_req", read_request_out, 0);
    reset = 1'b0;
    // 0xDB hit, slot answers 0x81 three cycles after the request
    address_in = 8'hDB;
    address_in_valid = 1'b1;
    step();
    check("db_req_early", read_request_out, 0);
    step();
    check("db_req", read_request_out, 1);
    check("db_enable", enable_out, 4'b0001);
    step(3);
    check("db_req_pulse", read_request_out, 0);
    check("db_wait_valid", cipo_out_valid, 0);
    answer(8'h81);
    check("db_cipo", cipo_out, 8'h81);
    check("db_cipo_valid", cipo_out_valid, 1);
    deselect();
    check("db_desel_enable", enable_out, 0);
    check("db_desel_valid", cipo_out_valid, 0);
    check("db_desel_cipo_kept", cipo_out, 8'h81);
    step();
    // 0xB5 with three data bytes
    req0 = n_req;
    wr0 = n_wr;
    start(8'hB5);
    check("b5_enable", enable_out, 4'b0010);
    answer(8'h11);
    send_byte(8'h00, 8'd0);
    answer(8'h22);
    send_byte(8'hFF, 8'd1);
    answer(8'h33);
    check("b5_cipo", cipo_out, 8'h33);
    send_byte(8'h00, 8'd2);
    deselect();
    check("b5_requests", n_req - req0, 4);
    check("b5_writes", n_wr - wr0, 3);
    check("b5_desel_index", byte_index_out, 0);
    step();
    // unmapped address
    req0 = n_req;
    wr0 = n_wr;
    start(8'h42);
    check("miss_enable", enable_out, 0);
    check("miss_cipo", cipo_out, 8'hFF);
    check("miss_valid", cipo_out_valid, 1);
    copi_in = 8'h5A;
    copi_in_valid = 1'b1;
    step(2);
    copi_in_valid = 1'b0;
    step(2);
    check("miss_requests", n_req - req0, 0);
    check("miss_writes", n_wr - wr0, 0);
    deselect();
    step();
    // address 0x00 never matches
    start(8'h00);
    check("zero_enable", enable_out, 0);
    check("zero_valid", cipo_out_valid, 1);
    deselect();
    step();
    // silent slot
    start(8'hDB);
    check("silent_req", read_request_out, 1);
`ifdef SPI_CONTROLLER_TIMEOUT_EN
    step(T);
    check("silent_before_timeout", cipo_out_valid, 0);
    step();
    check("silent_timeout_valid", cipo_out_valid, 1);
    check("silent_timeout_cipo", cipo_out, 8'hFF);
`else
    step(T + 10);
    check("silent_no_timeout", cipo_out_valid, 0);
    check("silent_still_enabled", enable_out, 4'b0001);
`endif
    deselect();
    check("silent_desel_enable", enable_out, 0);
    step();
    // deselect in the same cycle as a data byte rise
    start(8'hDB);
    answer(8'h44);
    wr0 = n_wr;
    address_in_valid = 1'b0;
    copi_in = 8'hAA;
    copi_in_valid = 1'b1;
    step();
    check("race_wvalid", write_valid_out, 0);
    check("race_enable", enable_out, 0);
    step();
    check("race_req", read_request_out, 0);
    check("race_writes", n_wr - wr0, 0);
    copi_in_valid = 1'b0;
    step();
    // byte index saturates at 255
    start(8'hB5);
    answer(8'h00);
    for (int k = 0; k < 257; k++) begin
      send_byte(8'(k), (k > 255) ? 8'hFF : 8'(k));
      answer(8'h00);
    end
    check("sat_index", byte_index_out, 8'hFF);
    deselect();
    step();
    // asynchronous reset while in HOLD
    start(8'hDB);
    answer(8'h33);
    #2 reset = 1'b1;
    #1;
    check("arst_cipo", cipo_out, 8'hFF);
    check("arst_valid", cipo_out_valid, 0);
    check("arst_enable", enable_out, 0);
    check("arst_index", byte_index_out, 0);
    address_in_valid = 1'b0;
    step(2);
    check("arst_wvalid", write_valid_out, 0);
    check("arst_req", read_request_out, 0);
    reset = 1'b0;
    step();
    start(8'hDB);
    check("post_req", read_request_out, 1);
    check("post_enable", enable_out, 4'b0001);
    answer(8'h5A);
    check("post_cipo", cipo_out, 8'h5A);
    check("post_valid", cipo_out_valid, 1);
    deselect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
